// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: one restoring-division step per clock on the
// operand magnitudes, then a sign correction. The quotient truncates toward zero
// and the remainder takes the sign of the dividend. Valid/ready handshakes are on
// both sides. A zero divisor spends one CALC cycle and then reports
// div_by_zero. The most-negative / -1 case wraps and reports overflow.
module seq_signed_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;

  // Division working registers. quo starts as |X| and is shifted out MSB-first
  // while quotient bits shift in at the LSB.
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          ovf_pend_q, ovf_pend_d;

  // Result registers, held stable through DONE.
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic          ovld_q, ovld_d;

  logic [N-1:0]  abs_x, abs_y;
  logic [N:0]    shift_val, trial;
  logic [N-1:0]  quo_step, rem_step;

  // Operand magnitudes. |-2^(N-1)| = 2^(N-1) still fits in N unsigned bits.
  always_comb begin
    abs_x = X[N-1] ? -X : X;
    abs_y = Y[N-1] ? -Y : Y;
  end

  // One restoring step. The trial subtraction is N+1 bits wide, so its MSB
  // is the borrow, and the partial remainder can never overflow.
  always_comb begin
    shift_val = {rem_q, quo_q[N-1]};
    trial     = shift_val - {1'b0, dvs_q};
    if (!trial[N]) begin
      rem_step = trial[N-1:0];
      quo_step = {quo_q[N-2:0], 1'b1};
    end else begin
      rem_step = shift_val[N-1:0];
      quo_step = {quo_q[N-2:0], 1'b0};
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath next values and handshake decode.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    q_d        = q_q;
    r_d        = r_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    ovld_d     = ovld_q;
    in_ready   = (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          quo_d      = abs_x;
          dvs_d      = abs_y;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quo_d  = X[N-1] ^ Y[N-1];
          neg_rem_d  = X[N-1];
          ovf_pend_d = (X == MOST_NEG) && (Y == '1);
          state_d    = CALC;
        end
      end

      CALC: begin
        if (dvs_q == '0) begin
          // Zero divisor: report -1 and hand the dividend back as the remainder.
          // The dividend is rebuilt from its magnitude and sign.
          q_d     = '1;
          r_d     = neg_rem_q ? -quo_q : quo_q;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          ovld_d  = 1'b1;
          state_d = DONE;
        end else begin
          quo_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            q_d     = neg_quo_q ? -quo_step : quo_step;
            r_d     = neg_rem_q ? -rem_step : rem_step;
            dbz_d   = 1'b0;
            ovf_d   = ovf_pend_q;
            ovld_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers.
  // NOTE: these are plain flops, not a memory array, so every one of them is
  // cleared by reset. An aborted operation then leaves no stale result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ovld_q     <= 1'b0;
    end else begin
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      ovld_q     <= ovld_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign out_valid   = ovld_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider (N=4). It covers sign combinations,
// overflow, divide by zero, backpressure and abort by reset. A sweep of all
// operand pairs is checked against integer arithmetic.
module tb_seq_signed_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_by_zero;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  seq_signed_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .X           (X),
    .Y           (Y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one operation. Inputs are driven 1 time unit after a rising edge.
  // The bench waits for out_valid and checks the result and the latency. It
  // holds out_ready low for bp cycles while toggling the operands, then
  // completes the handshake.
  task automatic op(input string tag, input int x, input int y, input int eq, input int er,
                    input logic edbz, input logic eovf, input int elat, input int bp);
    logic [N-1:0] eqv;
    logic [N-1:0] erv;
    int lat;
    eqv = eq[N-1:0];
    erv = er[N-1:0];
    @(posedge clk); #1;
    out_ready = (bp == 0);
    X = x[N-1:0];
    Y = y[N-1:0];
    in_valid = 1'b1;
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;             // accept edge k
    in_valid = 1'b0;
    X = ~X;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".result"}, {22'd0, Q, R, div_by_zero, overflow}, {22'd0, eqv, erv, edbz, eovf});
    for (int i = 0; i < bp; i++) begin
      X = X + 4'd3;
      Y = Y ^ 4'd5;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, ".bp_hold"}, {24'd0, out_valid, in_ready, Q, R[1:0]}, {24'd0, 1'b1, 1'b0, eqv, erv[1:0]});
      check({tag, ".bp_hold_r"}, 32'(R), 32'(erv));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;             // result handshake
    check({tag, ".after_hs"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    X = '0;
    Y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outputs", {22'd0, Q, R, div_by_zero, overflow}, 32'd0);
    check("reset.handshake", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    rst_n = 1'b1;

    op("pp", 7, 2, 3, 1, 1'b0, 1'b0, 4, 0);
    op("np", -7, 2, -3, -1, 1'b0, 1'b0, 4, 0);
    op("pn", 7, -2, -3, 1, 1'b0, 1'b0, 4, 0);
    op("nn", -7, -2, 3, -1, 1'b0, 1'b0, 4, 0);
    op("min3", -8, 3, -2, -2, 1'b0, 1'b0, 4, 0);
    op("ovf", -8, -1, -8, 0, 1'b0, 1'b1, 4, 0);
    op("dbz", 5, 0, -1, 5, 1'b1, 1'b0, 1, 0);
    op("bp", -5, 2, -2, -1, 1'b0, 1'b0, 4, 3);
    op("after_bp", 6, 4, 1, 2, 1'b0, 1'b0, 4, 0);

    // Abort by reset two edges into CALC.
    @(posedge clk); #1;
    X = 4'd7;
    Y = 4'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;             // accept
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.outputs", {22'd0, Q, R, div_by_zero, overflow}, 32'd0);
    check("abort.handshake", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort.no_result", 32'(seen), 32'd0);

    // Sweep all operand pairs against integer division.
    for (int xi = -8; xi < 8; xi++) begin
      for (int yi = -8; yi < 8; yi++) begin
        int eq;
        int er;
        if (yi == 0) begin
          eq = -1;
          er = xi;
        end else begin
          eq = xi / yi;
          er = xi % yi;
        end
        op($sformatf("sweep_%0d_%0d", xi, yi), xi, yi, eq, er, yi == 0,
           (xi == -8) && (yi == -1), (yi == 0) ? 1 : 4, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
